fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter DIV_LAT, default 24: cycles the FP ALU enables are held for divide (1..63).
REQ-002 SHALL have parameter SQRT_LAT, default 24: cycles the FP ALU enables are held for sqrt (1..63).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: operation request present.
REQ-006 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-007 SHALL have port req_op, input, 4: opcode (0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 max, 6 min, 7 eq, 8 lt, 9 leq).
REQ-008 SHALL have ports req_a and req_b, input, 32 each: IEEE-754 single operands.
REQ-009 SHALL have port req_tag, input, 5: destination register tag.
REQ-010 SHALL have ports alu_rs1 and alu_rs2, output, 32 each: operands driven to the FP ALU read_data1 and read_data2.
REQ-011 SHALL have ports alu_add_en, alu_sub_en, alu_mul_en, alu_div_en, alu_sqrt_en, alu_max_en, alu_min_en, alu_eq_en, alu_lt_en, alu_leq_en, output, 1 each: one-hot FP ALU enables.
REQ-012 SHALL have port alu_data_out, input, 32: registered FP ALU result.
REQ-013 SHALL have ports res_valid, output, 1, and res_ready, input, 1: result handshake.
REQ-014 SHALL have ports res_data, output, 32, and res_tag, output, 5: captured result and its tag.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, EXEC, CAPT and DONE.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-018 SHALL, on accept, latch req_op, req_a, req_b and req_tag, load the hold counter with L, and enter EXEC, where L is DIV_LAT for op 3, SQRT_LAT for op 4, and 1 otherwise.
REQ-019 SHALL, in EXEC, drive alu_rs1 and alu_rs2 from the latched operands and assert exactly one enable matching the latched op, decrementing the counter each cycle.
REQ-020 SHALL move from EXEC to CAPT after exactly L EXEC cycles.
REQ-021 SHALL deassert all enables in CAPT, hold alu_rs1 and alu_rs2, and sample alu_data_out into res_data at the end of CAPT.
REQ-022 SHALL, in DONE, assert res_valid with res_data and res_tag stable until res_ready is sampled high, then return to IDLE.
REQ-023 SHALL give a latency of L+2 cycles from the accept edge to the first res_valid cycle (3 cycles for single-cycle ops).
REQ-024 SHALL drive all enables low, and alu_rs1 and alu_rs2 to zero, in IDLE and DONE.
REQ-025 SHALL never assert more than one enable in any cycle.
REQ-026 SHALL ignore req_valid outside IDLE, with no queuing.
REQ-027 SHALL not accept a new request in the same cycle the DONE handshake completes; the earliest next accept is the following cycle.
REQ-028 SHALL treat a counter width of 6 bits as sufficient; DIV_LAT or SQRT_LAT of 0 is illegal.

Reset
REQ-029 SHALL, when rst is high at a rising edge, enter IDLE from any state, abandoning any operation in flight.
REQ-030 SHALL reset outputs to: req_ready 1 (first cycle after reset), res_valid 0, res_data 0, res_tag 0, all enables 0, alu_rs1 0, alu_rs2 0, busy 0.
REQ-031 SHALL give rst priority over a simultaneous req_valid.

Configuration
REQ-032 SHALL, with macro FPU_ILLEGAL_OP_EN defined, add output illegal_op (1 bit): for ops 10..15 it asserts no enables, goes from accept directly to DONE with res_data 0, and asserts illegal_op together with res_valid.
REQ-033 SHALL, without FPU_ILLEGAL_OP_EN, have no illegal_op port, and treat ops 10..15 with L=1 and all enables low, returning res_data equal to the sampled alu_data_out (0).

Verification
REQ-034 SHALL cover: op 0, a=0x3F800000, b=0x40000000, tag 3, ALU model returning 0x40400000 -> alu_add_en high for 1 cycle, res_valid at cycle 3 with res_data 0x40400000, res_tag 3.
REQ-035 SHALL cover: op 3 with DIV_LAT=24 -> alu_div_en high for exactly 24 cycles, res_valid at cycle 26.
REQ-036 SHALL cover: res_ready held low for 5 cycles in DONE -> res_valid, res_data and res_tag stable; req_ready stays 0; a second req_valid is ignored.
REQ-037 SHALL cover: rst asserted in EXEC cycle 10 of op 4 -> next cycle IDLE, alu_sqrt_en 0, res_valid 0, req_ready 1.
REQ-038 SHALL cover: back-to-back ops 7 then 8, with req_valid held high -> second accepted the cycle after the first DONE handshake; enables one-hot throughout.
REQ-039 SHALL cover, with FPU_ILLEGAL_OP_EN: op 12 -> no enable asserted, res_valid at cycle 1 with res_data 0 and illegal_op 1.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one floating-point operation at a time to an
// external FP ALU. It holds the operands and one-hot enable for the
// operation's latency, captures the registered ALU result, and presents the
// result with its destination tag over a valid/ready handshake.
// Optional feature: define FPU_ILLEGAL_OP_EN to flag opcodes 10..15 on the
// illegal_op output and skip the ALU entirely for them.
module fpu_issue_ctrl #(
  parameter int DIV_LAT  = 24,
  parameter int SQRT_LAT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic        alu_add_en,
  output logic        alu_sub_en,
  output logic        alu_mul_en,
  output logic        alu_div_en,
  output logic        alu_sqrt_en,
  output logic        alu_max_en,
  output logic        alu_min_en,
  output logic        alu_eq_en,
  output logic        alu_lt_en,
  output logic        alu_leq_en,
  input  logic [31:0] alu_data_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_tag,
`ifdef FPU_ILLEGAL_OP_EN
  output logic        illegal_op,
`endif
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Request captured at accept; held for the whole operation.
  logic        [3:0]        op_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic        [4:0]        tag_p0;
  logic        [CNT_W-1:0] cnt;
  logic                     illegal_p0;

  logic                     accept;
  logic                     op_illegal;
  logic        [9:0]        en_vec;

  // Number of cycles the ALU enable is held for a given opcode.
  function automatic logic [CNT_W-1:0] hold_len(input logic [3:0] op);
    case (op)
      4'd3:    hold_len = CNT_W'(DIV_LAT);
      4'd4:    hold_len = CNT_W'(SQRT_LAT);
      default: hold_len = CNT_W'(1);
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign res_valid  = (state == DONE);
  assign accept     = req_valid && req_ready;
  assign op_illegal = (req_op > 4'd9);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef FPU_ILLEGAL_OP_EN
          state_next = op_illegal ? DONE : EXEC;
`else
          state_next = EXEC;
`endif
        end
      end
      EXEC:    if (cnt == CNT_W'(1)) state_next = CAPT;
      CAPT:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch: operands and tag are data, held without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= req_op;
      a_p0   <= req_a;
      b_p0   <= req_b;
      tag_p0 <= req_tag;
    end
  end

  // Hold counter: loaded at accept, counts down through EXEC.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (accept)         cnt <= hold_len(req_op);
    else if (state == EXEC)  cnt <= cnt - CNT_W'(1);
  end

  // Result capture at the end of CAPT; illegal ops complete immediately with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data   <= '0;
      res_tag    <= '0;
      illegal_p0 <= 1'b0;
    end else if (accept) begin
      illegal_p0 <= op_illegal;
`ifdef FPU_ILLEGAL_OP_EN
      if (op_illegal) begin
        res_data <= '0;
        res_tag  <= req_tag;
      end
`endif
    end else if (state == CAPT) begin
      res_data <= alu_data_out;
      res_tag  <= tag_p0;
    end
  end

`ifdef FPU_ILLEGAL_OP_EN
  assign illegal_op = (state == DONE) && illegal_p0;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_p0 & op_illegal;
`endif

  // Enable decode: opcode index equals enable bit position; ops above 9 drive none.
  always_comb begin
    en_vec = '0;
    if ((state == EXEC) && (op_p0 <= 4'd9)) en_vec = 10'd1 << op_p0;
  end

  assign alu_add_en  = en_vec[0];
  assign alu_sub_en  = en_vec[1];
  assign alu_mul_en  = en_vec[2];
  assign alu_div_en  = en_vec[3];
  assign alu_sqrt_en = en_vec[4];
  assign alu_max_en  = en_vec[5];
  assign alu_min_en  = en_vec[6];
  assign alu_eq_en   = en_vec[7];
  assign alu_lt_en   = en_vec[8];
  assign alu_leq_en  = en_vec[9];

  // Operands are presented while the ALU works and while its result is captured.
  assign alu_rs1 = ((state == EXEC) || (state == CAPT)) ? a_p0 : '0;
  assign alu_rs2 = ((state == EXEC) || (state == CAPT)) ? b_p0 : '0;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed stimulus with a timeline-based reference model
// and a registered stand-in for the FP ALU.
module tb_fpu_issue_ctrl;

  localparam int DIV_LAT  = 24;
  localparam int SQRT_LAT = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic [31:0] alu_rs1, alu_rs2;
  logic        alu_add_en, alu_sub_en, alu_mul_en, alu_div_en, alu_sqrt_en;
  logic        alu_max_en, alu_min_en, alu_eq_en, alu_lt_en, alu_leq_en;
  logic [31:0] alu_data_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        busy;
`ifdef FPU_ILLEGAL_OP_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int failures = 0;
  int en_total = 0;
  logic [31:0] alu_val = '0;

  fpu_issue_ctrl #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_add_en(alu_add_en), .alu_sub_en(alu_sub_en), .alu_mul_en(alu_mul_en),
    .alu_div_en(alu_div_en), .alu_sqrt_en(alu_sqrt_en), .alu_max_en(alu_max_en),
    .alu_min_en(alu_min_en), .alu_eq_en(alu_eq_en), .alu_lt_en(alu_lt_en),
    .alu_leq_en(alu_leq_en), .alu_data_out(alu_data_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag),
`ifdef FPU_ILLEGAL_OP_EN
    .illegal_op(illegal_op),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [9:0] en;
  assign en = {alu_leq_en, alu_lt_en, alu_eq_en, alu_min_en, alu_max_en,
               alu_sqrt_en, alu_div_en, alu_mul_en, alu_sub_en, alu_add_en};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Stand-in FP ALU: registered result is alu_val plus the enabled op index, zero when idle.
  always @(posedge clk) begin
    int idx;
    idx = 0;
    for (int i = 0; i < 10; i++) if (en[i]) idx = i;
    alu_data_out <= (|en) ? alu_val + 32'(idx) : 32'd0;
  end

  // Enable-cycle counter used for the hold-length checks.
  always @(negedge clk) if (|en) en_total++;

  // Reference model: one transaction described by its age since the accept edge.
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age = 0, m_L = 0, m_done_at = 0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_tag = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1;
      m_busy = 1'b0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_op = req_op; m_a = req_a; m_b = req_b; m_tag = req_tag;
          m_L = (req_op == 4'd3) ? DIV_LAT : (req_op == 4'd4) ? SQRT_LAT : 1;
          m_done_at = m_L + 2;
`ifdef FPU_ILLEGAL_OP_EN
          if (req_op > 4'd9) begin m_L = 0; m_done_at = 1; end
`endif
          m_res = (req_op <= 4'd9) ? alu_val + 32'(req_op) : 32'd0;
          m_busy = 1'b1;
          m_age = 1;
        end
      end else if (m_age >= m_done_at && res_ready) begin
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    bit ex, cp, dn;
    logic [9:0] exp_en;
    if (m_on) begin
      ex = m_busy && (m_age <= m_L) && (m_age < m_done_at);
      cp = m_busy && (m_age == m_L + 1) && (m_age < m_done_at);
      dn = m_busy && (m_age >= m_done_at);
      exp_en = (ex && m_op <= 4'd9) ? (10'd1 << m_op) : 10'd0;
      check("m_req_ready", 32'(req_ready), 32'(!m_busy));
      check("m_busy", 32'(busy), 32'(m_busy));
      check("m_enables", 32'(en), 32'(exp_en));
      check("m_onehot", 32'($countones(en) <= 1), 32'd1);
      check("m_rs1", alu_rs1, (ex || cp) ? m_a : 32'd0);
      check("m_rs2", alu_rs2, (ex || cp) ? m_b : 32'd0);
      check("m_res_valid", 32'(res_valid), 32'(dn));
      if (dn) begin
        check("m_res_data", res_data, m_res);
        check("m_res_tag", 32'(res_tag), 32'(m_tag));
      end
`ifdef FPU_ILLEGAL_OP_EN
      check("m_illegal_op", 32'(illegal_op), 32'(dn && m_op > 4'd9));
`endif
    end
  end

  // One transaction with literal latency, enable-count, data and tag expectations.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] val, input int stall,
                       input int exp_lat, input int exp_en, input logic [31:0] exp_data,
                       input logic exp_ill);
    int lat, base;
    alu_val = val;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    base = en_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("res_data", res_data, exp_data);
    check("res_tag", 32'(res_tag), 32'(tag));
`ifdef FPU_ILLEGAL_OP_EN
    check("illegal_op", 32'(illegal_op), 32'(exp_ill));
`else
    if (exp_ill) check("illegal_op_unexpected", 32'(exp_ill), 32'd0);
`endif
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_data", res_data, exp_data);
      check("stall_tag", 32'(res_tag), 32'(tag));
      check("stall_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_op = 4'd0; req_tag = 5'd31;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_valid", 32'(res_valid), 32'd0);
    check("en_cycles", 32'(en_total - base), 32'(exp_en));
  endtask

  initial begin
    int lat;
    logic [9:0] rv_mask, rdy_mask;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    check("rst_enables", 32'(en), 32'd0);
    check("rst_rs1", alu_rs1, 32'd0);
    check("rst_rs2", alu_rs2, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // add 1.0 + 2.0 -> 3.0
    do_op(4'd0, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 0, 3, 1, 32'h40400000, 1'b0);
    // divide holds its enable for the divide latency
    do_op(4'd3, 32'h40C00000, 32'h40000000, 5'd9, 32'h40400000, 0, DIV_LAT + 2, DIV_LAT,
          32'h40400003, 1'b0);
    // result held while res_ready is low; extra requests ignored
    do_op(4'd2, 32'h40000000, 32'h40400000, 5'd17, 32'h40C00000, 5, 3, 1, 32'h40C00002, 1'b0);
    do_op(4'd1, 32'h40400000, 32'h3F800000, 5'd1, 32'h12340000, 0, 3, 1, 32'h12340001, 1'b0);
    do_op(4'd6, 32'hBF800000, 32'h3F800000, 5'd30, 32'hBF800000, 2, 3, 1, 32'hBF800006, 1'b0);
    do_op(4'd9, 32'h3F800000, 32'h3F800000, 5'd5, 32'h00000000, 0, 3, 1, 32'h00000009, 1'b0);
    do_op(4'd4, 32'h41100000, 32'h00000000, 5'd7, 32'h40400000, 0, SQRT_LAT + 2, SQRT_LAT,
          32'h40400004, 1'b0);
`ifdef FPU_ILLEGAL_OP_EN
    do_op(4'd12, 32'h11111111, 32'h22222222, 5'd12, 32'h55550000, 0, 1, 0, 32'd0, 1'b1);
`else
    do_op(4'd12, 32'h11111111, 32'h22222222, 5'd12, 32'h55550000, 0, 3, 0, 32'd0, 1'b0);
`endif

    // reset during cycle 10 of a sqrt
    alu_val = 32'h0BAD0000;
    req_op = 4'd4; req_a = 32'h40800000; req_b = '0; req_tag = 5'd22; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin @(posedge clk); #1; lat++; end
    check("pre_rst_sqrt_en", 32'(alu_sqrt_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_sqrt_en", 32'(alu_sqrt_en), 32'd0);
    check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // back-to-back eq then lt with req_valid held high
    alu_val = 32'h00000100;
    req_op = 4'd7; req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 5'd4;
    req_valid = 1'b1; res_ready = 1'b1;
    rv_mask = '0; rdy_mask = '0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      rv_mask[c] = res_valid;
      rdy_mask[c] = req_ready;
      if (c == 1) begin req_op = 4'd8; req_tag = 5'd8; end
      if (c == 5) req_valid = 1'b0;
    end
    res_ready = 1'b0;
    check("b2b_res_valid_cycles", 32'(rv_mask), 32'h088);
    check("b2b_req_ready_cycles", 32'(rdy_mask), 32'h310);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
